// File: rtl/wbicap_bridge.sv
// wbicap_bridge: pipelined Wishbone slave feeding a Xilinx ICAP port through a divided ICAP clock.
// Define WBICAP_TIMEOUT_EN to build the busy timeout that aborts a request with o_wb_err.
module wbicap_bridge #(
    parameter int CLK_DIV_LOG2   = 3,
    parameter int DW             = 32,
    parameter int BITREV         = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [DW-1:0] i_wb_data,
    output logic          o_wb_ack,
    output logic          o_wb_err,
    output logic          o_wb_stall,
    output logic [DW-1:0] o_wb_data,
    output logic          o_icap_clk,
    output logic          o_icap_ce_n,
    output logic          o_icap_we_n,
    output logic [15:0]   o_icap_data,
    input  logic          i_icap_busy,
    input  logic [15:0]   i_icap_data
);
    localparam int CW = CLK_DIV_LOG2;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << CW) - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(1 << (CW - 1));
    localparam bit TWO_HALVES = (DW == 32);

    if (CLK_DIV_LOG2 < 2 || CLK_DIV_LOG2 > 6) begin : g_bad_div
        $error("wbicap_bridge: CLK_DIV_LOG2 must be 2..6");
    end
    if (DW != 16 && DW != 32) begin : g_bad_dw
        $error("wbicap_bridge: DW must be 16 or 32");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_to
        $error("wbicap_bridge: TIMEOUT_CYCLES must be 1..255");
    end

    typedef enum logic [1:0] {IDLE, WAIT_DRIVE, XFER, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_q, clk_d, ce_n_q, ce_n_d, we_n_q, we_n_d;
    logic          ack_q, ack_d, we_q, we_d, half_q, half_d;
    logic [15:0]   icap_q, icap_d, wsel, rsel;
    logic [DW-1:0] wdat_q, wdat_d, rdat_q, rdat_d;
    logic          drive, sample;
`ifdef WBICAP_TIMEOUT_EN
    logic [7:0]    to_q, to_d;
    logic          err_q, err_d, errp_q, errp_d;
`endif

    // Byte-wise bit reversal: bit i maps to bit i^7 inside the same byte.
    function automatic logic [15:0] brev(input logic [15:0] x);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = x[i ^ 7];
        return (BITREV != 0) ? r : x;
    endfunction

    always_comb begin
        drive   = (cnt_q == '0);
        sample  = (cnt_q == CNT_LAST);
        cnt_d   = sample ? '0 : cnt_q + 1'b1;
        clk_d   = (cnt_d >= CNT_MID);
        wsel    = (TWO_HALVES && half_q) ? wdat_q[15:0] : wdat_q[DW-1 -: 16];
        rsel    = brev(i_icap_data);
        state_d = state_q;
        ce_n_d  = ce_n_q;
        we_n_d  = we_n_q;
        icap_d  = icap_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        half_d  = half_q;
        ack_d   = 1'b0;
`ifdef WBICAP_TIMEOUT_EN
        to_d    = to_q;
        errp_d  = errp_q;
        err_d   = 1'b0;
`endif
        if (drive && (state_q == IDLE || state_q == DONE || !i_wb_cyc)) begin
            ce_n_d = 1'b1;
            we_n_d = 1'b1;
            icap_d = 16'hFFFF;
        end
        if (state_q != IDLE && !i_wb_cyc) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (i_wb_cyc && i_wb_stb) begin
                    we_d    = i_wb_we;
                    wdat_d  = i_wb_data;
                    half_d  = 1'b0;
                    state_d = WAIT_DRIVE;
`ifdef WBICAP_TIMEOUT_EN
                    errp_d  = 1'b0;
`endif
                end
                WAIT_DRIVE: if (drive) begin
                    ce_n_d  = 1'b0;
                    we_n_d  = ~we_q;
                    icap_d  = we_q ? brev(wsel) : 16'hFFFF;
                    state_d = XFER;
`ifdef WBICAP_TIMEOUT_EN
                    to_d    = '0;
`endif
                end
                XFER: begin
                    if (sample && !i_icap_busy) begin
                        if (TWO_HALVES && half_q) rdat_d[15:0] = rsel;
                        else rdat_d[DW-1 -: 16] = rsel;
                        if (TWO_HALVES && !half_q) begin
                            half_d  = 1'b1;
                            state_d = WAIT_DRIVE;
                        end else begin
                            state_d = DONE;
                        end
                    end
`ifdef WBICAP_TIMEOUT_EN
                    else if (sample) begin
                        to_d = to_q + 8'd1;
                        if (to_d == 8'(TIMEOUT_CYCLES)) begin
                            errp_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
`endif
                end
                DONE: begin
`ifdef WBICAP_TIMEOUT_EN
                    ack_d = ~errp_q;
                    err_d = errp_q;
`else
                    ack_d = 1'b1;
`endif
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            icap_q  <= 16'hFFFF;
            ack_q   <= 1'b0;
            we_q    <= 1'b0;
            half_q  <= 1'b0;
            wdat_q  <= '0;
            rdat_q  <= '0;
`ifdef WBICAP_TIMEOUT_EN
            to_q    <= '0;
            err_q   <= 1'b0;
            errp_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
            ce_n_q  <= ce_n_d;
            we_n_q  <= we_n_d;
            icap_q  <= icap_d;
            ack_q   <= ack_d;
            we_q    <= we_d;
            half_q  <= half_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
`ifdef WBICAP_TIMEOUT_EN
            to_q    <= to_d;
            err_q   <= err_d;
            errp_q  <= errp_d;
`endif
        end
    end

    assign o_wb_ack    = ack_q;
    assign o_wb_stall  = (state_q != IDLE);
    assign o_wb_data   = rdat_q;
    assign o_icap_clk  = clk_q;
    assign o_icap_ce_n = ce_n_q;
    assign o_icap_we_n = we_n_q;
    assign o_icap_data = icap_q;
`ifdef WBICAP_TIMEOUT_EN
    assign o_wb_err    = err_q;
`else
    assign o_wb_err    = 1'b0;
`endif
endmodule

// File: tb/tb_wbicap_bridge.sv
// tb_wbicap_bridge: directed checks of wbicap_bridge with P=8, DW=32, BITREV=1, TIMEOUT_CYCLES=16.
module tb_wbicap_bridge;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] wdata = '0, rdata;
    logic        ack, err, stall, icap_clk, ce_n, we_n;
    logic [15:0] icap_o, icap_i = '0;
    logic        busy = 1'b0;
    int          n_cmp = 0, n_err = 0;
    logic [16:0] log_q[$];

    always #5 clk = ~clk;

    wbicap_bridge #(.CLK_DIV_LOG2(3), .DW(32), .BITREV(1), .TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_data(wdata),
        .o_wb_ack(ack), .o_wb_err(err), .o_wb_stall(stall), .o_wb_data(rdata),
        .o_icap_clk(icap_clk), .o_icap_ce_n(ce_n), .o_icap_we_n(we_n), .o_icap_data(icap_o),
        .i_icap_busy(busy), .i_icap_data(icap_i)
    );

    // Record what the ICAP would latch on each rising ICAP clock while enabled.
    always @(posedge icap_clk) if (!ce_n) log_q.push_back({we_n, icap_o});

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] log_at(input int i);
        return (i < log_q.size()) ? log_q[i] : 17'hx;
    endfunction

    task automatic align();
        int k = 0;
        logic prev = icap_clk;
        forever begin
            tick();
            k++;
            if (prev && !icap_clk) return;
            prev = icap_clk;
            if (k > 64) begin
                n_cmp++;
                n_err++;
                $error("FAIL align: icap clock never fell within %0d cycles", k);
                return;
            end
        end
    endtask

    task automatic start(input logic w, input logic [31:0] d);
        align();
        log_q.delete();
        cyc = 1'b1; stb = 1'b1; we = w; wdata = d;
        tick();
        stb = 1'b0;
    endtask

    task automatic wait_resp(output int n, output logic a, output logic e);
        n = 0; a = 1'b0; e = 1'b0;
        while (n < 400 && !a && !e) begin
            tick();
            n++;
            a = ack;
            e = err;
        end
    endtask

    task automatic quiet(input int n, output int r);
        r = 0;
        repeat (n) begin
            tick();
            if (ack || err) r++;
        end
    endtask

    task automatic wait_release(input string tag);
        int k = 0;
        while (ce_n !== 1'b1 && k < 16) begin
            tick();
            k++;
        end
        chk(tag, ce_n, 1'b1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " ack"}, ack, 1'b0);
        chk({tag, " err"}, err, 1'b0);
        chk({tag, " stall"}, stall, 1'b0);
        chk({tag, " rdata"}, rdata, 32'h0);
        chk({tag, " icap_clk"}, icap_clk, 1'b0);
        chk({tag, " ce_n"}, ce_n, 1'b1);
        chk({tag, " we_n"}, we_n, 1'b1);
        chk({tag, " icap_data"}, icap_o, 16'hFFFF);
    endtask

    initial begin
        int n, k, s, r;
        logic a, e, prev;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("reset");
        repeat (3) @(posedge clk);
        #4 rst_n = 1'b1;
        tick();

        // plain write, two halves
        start(1'b1, 32'hAA995566);
        chk("wr stall", stall, 1'b1);
        wait_resp(n, a, e);
        chk("wr ack", a, 1'b1);
        chk("wr err", e, 1'b0);
        chk("wr latency", n, 24);
        chk("wr stall at ack", stall, 1'b0);
        chk("wr icap count", log_q.size(), 2);
        chk("wr half0", log_at(0), {1'b0, 16'h5599});
        chk("wr half1", log_at(1), {1'b0, 16'hAA66});
        chk("wr release", ce_n, 1'b1);
        tick();
        chk("wr ack pulse", ack, 1'b0);
        quiet(20, r);
        chk("wr single resp", r, 0);
        cyc = 1'b0;

        // read, bit reversed capture
        icap_i = 16'h0080;
        start(1'b0, 32'h0);
        wait_resp(n, a, e);
        chk("rd ack", a, 1'b1);
        chk("rd latency", n, 24);
        chk("rd data", rdata, 32'h00010001);
        chk("rd icap count", log_q.size(), 2);
        chk("rd half0", log_at(0), {1'b1, 16'hFFFF});
        chk("rd half1", log_at(1), {1'b1, 16'hFFFF});
        quiet(10, r);
        chk("rd single resp", r, 0);
        cyc = 1'b0;
        icap_i = 16'h0000;

        // busy for three sample ticks on the first half
        busy = 1'b1;
        start(1'b1, 32'hAA995566);
        k = 0; s = 0; prev = icap_clk;
        while (s < 3 && k < 100) begin
            tick();
            k++;
            if (prev && !icap_clk && !ce_n) s++;
            prev = icap_clk;
        end
        busy = 1'b0;
        chk("busy ticks seen", s, 3);
        wait_resp(n, a, e);
        chk("busy ack", a, 1'b1);
        chk("busy latency", k + n, 48);
        chk("busy icap count", log_q.size(), 5);
        chk("busy held", log_at(3), {1'b0, 16'h5599});
        chk("busy half1", log_at(4), {1'b0, 16'hAA66});
        cyc = 1'b0;
        tick();

        // busy held permanently
        busy = 1'b1;
        start(1'b1, 32'h12345678);
`ifdef WBICAP_TIMEOUT_EN
        wait_resp(n, a, e);
        chk("to err", e, 1'b1);
        chk("to ack", a, 1'b0);
        chk("to latency", n, 136);
        tick();
        chk("to err pulse", err, 1'b0);
        wait_release("to release");
        quiet(10, r);
        chk("to single resp", r, 0);
`else
        quiet(200, r);
        chk("hang no resp", r, 0);
        chk("hang stall", stall, 1'b1);
`endif
        cyc = 1'b0;
        tick();
        chk("to idle", stall, 1'b0);
        busy = 1'b0;
        wait_release("to idle release");

        // cyc dropped during second half
        start(1'b1, 32'h0F0FF0F0);
        repeat (20) tick();
        chk("abort in xfer", ce_n, 1'b0);
        cyc = 1'b0;
        tick();
        chk("abort stall", stall, 1'b0);
        wait_release("abort release");
        quiet(30, r);
        chk("abort no resp", r, 0);

        // reset mid-read
        icap_i = 16'h0080;
        start(1'b0, 32'h0);
        repeat (12) tick();
        #3 rst_n = 1'b0;
        #1 chk_reset_vals("midreset");
        #3 rst_n = 1'b1;
        quiet(40, r);
        chk("midreset no resp", r, 0);
        chk("midreset stall", stall, 1'b0);
        cyc = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wbicap_bridge.md
WBICAP_BRIDGE -- requirements
Module: wbicap_bridge

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- CLK_DIV_LOG2, 3: ICAP clock period P = 2^CLK_DIV_LOG2 i_clk cycles; legal range 2..6.
- DW, 32: Wishbone data width, 16 or 32; each bus word maps to DW/16 ICAP transfers ("halves").
- BITREV, 1: 1 = reverse bit order within each byte on both directions; 0 = pass through.
- TIMEOUT_CYCLES, 16: ICAP cycles of continuous BUSY tolerated before abort; legal range 1..255.
REQ-002 Ports (name, direction, width, meaning), one per line:
- i_clk, in, 1: sole clock.
- i_reset_n, in, 1: reset, asynchronous, active-low.
- i_wb_cyc, i_wb_stb, i_wb_we, in, 1 each: pipelined Wishbone request.
- i_wb_data, in, DW: write data.
- o_wb_ack, o_wb_err, o_wb_stall, out, 1 each: Wishbone response.
- o_wb_data, out, DW: read data.
- o_icap_clk, o_icap_ce_n, o_icap_we_n, out, 1 each: ICAP clock, active-low enable, active-low write.
- o_icap_data, out, 16: ICAP input word.
- i_icap_busy, in, 1: ICAP BUSY.
- i_icap_data, in, 16: ICAP output word.

Function
REQ-003 Free-running divider cnt counts 0..P-1 and wraps; o_icap_clk = (cnt >= P/2), registered.
REQ-004 "Drive tick" = i_clk edge with cnt==0; o_icap_ce_n, o_icap_we_n and o_icap_data change only on drive ticks.
REQ-005 "Sample tick" = i_clk edge with cnt==P-1; i_icap_busy and i_icap_data are sampled only on sample ticks.
REQ-006 FSM states: IDLE, WAIT_DRIVE, XFER, DONE. o_wb_stall = (state != IDLE).
REQ-007 IDLE: on i_wb_cyc && i_wb_stb, latch we and data, set half index to 0 (most-significant half first), and go to WAIT_DRIVE.
REQ-008 WAIT_DRIVE: on the next drive tick, drive ce_n=0, we_n=~we, data = selected half (bit-reversed per byte if BITREV; 16'hFFFF on reads), clear the timeout counter, and go to XFER.
REQ-009 XFER, on a sample tick with busy=0:
- Capture the (bit-reversed) read half into o_wb_data, most-significant half first.
- If more halves remain, increment the half index and drive the next half on the next drive tick (ce_n stays low).
- Otherwise go to DONE.
REQ-010 XFER, on a sample tick with busy=1: hold all ICAP outputs and increment the timeout counter (8 bits). On reaching TIMEOUT_CYCLES, pulse o_wb_err for one cycle, issue no ack, and go to DONE.
REQ-011 DONE: pulse o_wb_ack (or o_wb_err per REQ-010) for exactly one cycle on the next i_clk edge, then return to IDLE. ce_n returns to 1, we_n to 1 and data to 16'hFFFF at the next drive tick unless a new request has reached WAIT_DRIVE by then.
REQ-012 i_wb_cyc low in any non-IDLE state: abort, issue no ack or err, return to IDLE, and release the ICAP outputs at the next drive tick.
REQ-013 Ack/err are never asserted while i_wb_cyc is low. At most one response per accepted request.
REQ-014 Minimum latency from acceptance to ack is (DW/16)*P + up to P cycles of alignment to the drive tick, plus 1 cycle.

Reset
REQ-015 While i_reset_n is low, immediately set: cnt=0, state=IDLE, o_wb_ack=0, o_wb_err=0, o_wb_stall=0, o_wb_data=0, o_icap_clk=0, o_icap_ce_n=1, o_icap_we_n=1, o_icap_data=16'hFFFF, timeout counter=0.
REQ-016 Reset asserted mid-transfer discards the transfer with no response; operation resumes from cnt=0 after release.

Configuration
REQ-017 Macro WBICAP_TIMEOUT_EN:
- Defined: REQ-010 timeout and the o_wb_err behaviour apply.
- Undefined: no timeout counter is built, o_wb_err is tied to 0, and XFER waits on busy indefinitely.

Verification (CLK_DIV_LOG2=3, DW=32, BITREV=1, TIMEOUT_CYCLES=16, macro defined)
REQ-018 Write 32'hAA995566 with busy=0 -> ICAP sees 16'h5599 then 16'hAA66 with we_n=0 across 2 ICAP cycles; a single ack; stall high until the ack.
REQ-019 Read with i_icap_data=16'h0080 -> o_wb_data=32'h00010001 at the ack; we_n=1 and o_icap_data=16'hFFFF during the transfer.
REQ-020 Write with busy held high for 3 sample ticks on the first half -> first half held stable; ack delayed by 24 i_clk versus REQ-018.
REQ-021 Busy held high permanently -> o_wb_err pulses once after 16 sample ticks, no ack, ce_n=1 at the next drive tick.
REQ-022 Drop i_wb_cyc during the second half -> no ack or err, state IDLE, ce_n=1 at the next drive tick.
REQ-023 Assert i_reset_n low mid-read -> all outputs at their REQ-015 values in the same cycle; no response after release.
